// File: rtl/skip_pc_ctrl.sv
// PC and instruction-valid controller for the 3-stage ez8 pipeline: skip annul, jump/call/ret redirect, stall hold.
// Optional hardware return stack enabled by defining CALL_STACK_EN.
module skip_pc_ctrl #(
    parameter int unsigned PC_WIDTH    = 12,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                ex_is_skip,
    input  logic                skip,
    input  logic                ex_jump,
    input  logic                ex_call,
    input  logic                ex_ret,
    input  logic [PC_WIDTH-1:0] ex_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic                dec_valid,
    output logic                ex_valid,
    output logic [PC_WIDTH-1:0] ex_pc,
    output logic                stack_ovf
);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] dec_pc_q, dec_pc_d;
    logic [PC_WIDTH-1:0] ex_pc_q, ex_pc_d;
    logic                dec_valid_q, dec_valid_d;
    logic                ex_valid_q, ex_valid_d;

    logic                is_call_c;
    logic                is_ret_c;
    logic                redirect_c;
    logic                annul_c;
    logic [PC_WIDTH-1:0] ret_addr_c;

    // Call and ret together decode as ret
    always_comb begin
        is_ret_c  = ex_ret;
        is_call_c = ex_call & ~ex_ret;
        annul_c   = ex_valid_q & ex_is_skip & skip;
`ifdef CALL_STACK_EN
        redirect_c = ex_valid_q & (ex_jump | is_call_c | is_ret_c);
`else
        // Without a stack, ret is a nop and call is a plain jump
        redirect_c = ex_valid_q & (ex_jump | is_call_c);
`endif
    end

`ifdef CALL_STACK_EN
    localparam int unsigned SP_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned CNT_W = SP_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STACK_DEPTH);

    logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [SP_W-1:0]     sp_q, sp_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                push_c;
    logic                pop_c;
    logic [SP_W-1:0]     pop_idx_c;

    // Circular LIFO: pointer wraps, occupancy count detects over/underflow
    always_comb begin
        push_c     = ~stall & ex_valid_q & is_call_c;
        pop_c      = ~stall & ex_valid_q & is_ret_c;
        pop_idx_c  = sp_q - SP_W'(1);
        ret_addr_c = stack_q[pop_idx_c];
        sp_d       = sp_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        if (push_c) begin
            sp_d = sp_q + SP_W'(1);
            if (cnt_q == CNT_FULL) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop_c) begin
            sp_d = pop_idx_c;
            if (cnt_q == '0) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (push_c) begin
                stack_q[sp_q] <= ex_pc_q + PC_WIDTH'(1);
            end
        end
    end

    assign stack_ovf = ovf_q;
`else
    assign ret_addr_c = '0;
    assign stack_ovf  = 1'b0;
`endif

    // Pipeline advance: redirect beats annul beats normal; stall holds everything
    always_comb begin
        pc_d        = pc_q;
        dec_pc_d    = dec_pc_q;
        ex_pc_d     = ex_pc_q;
        dec_valid_d = dec_valid_q;
        ex_valid_d  = ex_valid_q;
        if (!stall) begin
            pc_d        = pc_q + PC_WIDTH'(1);
            dec_pc_d    = pc_q;
            dec_valid_d = 1'b1;
            ex_pc_d     = dec_pc_q;
            ex_valid_d  = dec_valid_q;
            if (redirect_c) begin
                pc_d        = is_ret_c ? ret_addr_c : ex_target;
                dec_valid_d = 1'b0;
                ex_valid_d  = 1'b0;
            end else if (annul_c) begin
                ex_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= '0;
            dec_pc_q    <= '0;
            ex_pc_q     <= '0;
            dec_valid_q <= 1'b0;
            ex_valid_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            dec_pc_q    <= dec_pc_d;
            ex_pc_q     <= ex_pc_d;
            dec_valid_q <= dec_valid_d;
            ex_valid_q  <= ex_valid_d;
        end
    end

    assign pc        = pc_q;
    assign dec_valid = dec_valid_q;
    assign ex_valid  = ex_valid_q;
    assign ex_pc     = ex_pc_q;

endmodule

// File: tb/tb_skip_pc_ctrl.sv
// Directed-vector bench for skip_pc_ctrl; stack scenarios run only when CALL_STACK_EN is defined.
module tb_skip_pc_ctrl;

    localparam int unsigned PC_WIDTH = 12;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                stall;
    logic                ex_is_skip;
    logic                skip;
    logic                ex_jump;
    logic                ex_call;
    logic                ex_ret;
    logic [PC_WIDTH-1:0] ex_target;
    logic [PC_WIDTH-1:0] pc;
    logic                dec_valid;
    logic                ex_valid;
    logic [PC_WIDTH-1:0] ex_pc;
    logic                stack_ovf;

    int n_total = 0;
    int n_bad   = 0;

    skip_pc_ctrl #(.PC_WIDTH(PC_WIDTH), .STACK_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .ex_is_skip (ex_is_skip),
        .skip       (skip),
        .ex_jump    (ex_jump),
        .ex_call    (ex_call),
        .ex_ret     (ex_ret),
        .ex_target  (ex_target),
        .pc         (pc),
        .dec_valid  (dec_valid),
        .ex_valid   (ex_valid),
        .ex_pc      (ex_pc),
        .stack_ovf  (stack_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_dir();
        ex_is_skip = 1'b0;
        skip       = 1'b0;
        ex_jump    = 1'b0;
        ex_call    = 1'b0;
        ex_ret     = 1'b0;
    endtask

    // Issue one redirect from a live execute slot and follow it through both bubbles
    task automatic do_redir(input string tag, input logic j, input logic c, input logic r,
                            input logic [PC_WIDTH-1:0] tgt, input logic [PC_WIDTH-1:0] exp_pc);
        ex_jump   = j;
        ex_call   = c;
        ex_ret    = r;
        ex_target = tgt;
        step();
        chk({tag, "_pc"}, 32'(pc), 32'(exp_pc));
        chk({tag, "_bub_dv"}, 32'(dec_valid), 32'd0);
        chk({tag, "_bub_ev"}, 32'(ex_valid), 32'd0);
        clear_dir();
        step();
        chk({tag, "_bub2_ev"}, 32'(ex_valid), 32'd0);
        step();
        chk({tag, "_land_ev"}, 32'(ex_valid), 32'd1);
        chk({tag, "_land_expc"}, 32'(ex_pc), 32'(exp_pc));
    endtask

    initial begin
        rst_n     = 1'b0;
        stall     = 1'b0;
        ex_target = '0;
        clear_dir();
        step();
        step();
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_dv", 32'(dec_valid), 32'd0);
        chk("rst_ev", 32'(ex_valid), 32'd0);
        chk("rst_expc", 32'(ex_pc), 32'd0);
        chk("rst_ovf", 32'(stack_ovf), 32'd0);

        rst_n = 1'b1;
        step();
        chk("c1_pc", 32'(pc), 32'd1);
        chk("c1_dv", 32'(dec_valid), 32'd1);
        chk("c1_ev", 32'(ex_valid), 32'd0);
        step();
        chk("c2_pc", 32'(pc), 32'd2);
        chk("c2_ev", 32'(ex_valid), 32'd1);
        chk("c2_expc", 32'(ex_pc), 32'd0);
        step();
        chk("c3_pc", 32'(pc), 32'd3);
        chk("c3_expc", 32'(ex_pc), 32'd1);
        repeat (4) step();
        chk("at5_expc", 32'(ex_pc), 32'd5);
        chk("at5_ev", 32'(ex_valid), 32'd1);

        // Skip taken at 5 annuls 6; skip asserted on the annulled 6 is ignored
        ex_is_skip = 1'b1;
        skip       = 1'b1;
        step();
        chk("annul_ev", 32'(ex_valid), 32'd0);
        chk("annul_expc", 32'(ex_pc), 32'd6);
        chk("annul_pc", 32'(pc), 32'd8);
        chk("annul_dv", 32'(dec_valid), 32'd1);
        step();
        chk("post_annul_ev", 32'(ex_valid), 32'd1);
        chk("post_annul_expc", 32'(ex_pc), 32'd7);
        skip = 1'b0;
        step();
        chk("noskip_ev", 32'(ex_valid), 32'd1);
        chk("noskip_expc", 32'(ex_pc), 32'd8);
        clear_dir();
        step();
        step();
        chk("at10_expc", 32'(ex_pc), 32'd10);
        chk("at10_pc", 32'(pc), 32'd12);

        do_redir("jmp", 1'b1, 1'b0, 1'b0, 12'h100, 12'h100);
        chk("jmp_pc_after", 32'(pc), 32'h102);

        // Skip condition held through a 3-cycle stall, applied on release
        stall      = 1'b1;
        ex_is_skip = 1'b1;
        skip       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", 32'(pc), 32'h102);
            chk("stall_dv", 32'(dec_valid), 32'd1);
            chk("stall_ev", 32'(ex_valid), 32'd1);
            chk("stall_expc", 32'(ex_pc), 32'h100);
        end
        stall = 1'b0;
        step();
        chk("unstall_ev", 32'(ex_valid), 32'd0);
        chk("unstall_expc", 32'(ex_pc), 32'h101);
        chk("unstall_pc", 32'(pc), 32'h103);
        clear_dir();
        step();
        chk("unstall2_ev", 32'(ex_valid), 32'd1);
        chk("unstall2_expc", 32'(ex_pc), 32'h102);

        // Jump beats a simultaneous true skip
        ex_is_skip = 1'b1;
        skip       = 1'b1;
        do_redir("jmpskip", 1'b1, 1'b0, 1'b0, 12'h200, 12'h200);

`ifndef CALL_STACK_EN
        ex_ret = 1'b1;
        step();
        chk("retnop_pc", 32'(pc), 32'h203);
        chk("retnop_dv", 32'(dec_valid), 32'd1);
        chk("retnop_ev", 32'(ex_valid), 32'd1);
        chk("retnop_expc", 32'(ex_pc), 32'h201);
        clear_dir();
        do_redir("calljmp", 1'b0, 1'b1, 1'b0, 12'hFFF, 12'hFFF);
        chk("wrap_pc", 32'(pc), 32'h001);
        chk("noovf", 32'(stack_ovf), 32'd0);
`else
        do_redir("tojmp20", 1'b1, 1'b0, 1'b0, 12'h020, 12'h020);
        do_redir("call80", 1'b0, 1'b1, 1'b0, 12'h080, 12'h080);
        do_redir("ret21", 1'b0, 1'b0, 1'b1, 12'h000, 12'h021);
        chk("ret21_ovf", 32'(stack_ovf), 32'd0);
        do_redir("nest1", 1'b0, 1'b1, 1'b0, 12'h040, 12'h040);
        do_redir("nest2", 1'b0, 1'b1, 1'b0, 12'h050, 12'h050);
        do_redir("nest3", 1'b0, 1'b1, 1'b0, 12'h060, 12'h060);
        do_redir("nest4", 1'b0, 1'b1, 1'b0, 12'h070, 12'h070);
        chk("nest4_ovf", 32'(stack_ovf), 32'd0);
        do_redir("nest5", 1'b0, 1'b1, 1'b0, 12'h090, 12'h090);
        chk("nest5_ovf", 32'(stack_ovf), 32'd1);
        do_redir("ret71", 1'b0, 1'b0, 1'b1, 12'h000, 12'h071);
        chk("ret71_ovf", 32'(stack_ovf), 32'd1);
`endif

        // Asynchronous reset mid-run clears state without a clock edge
        rst_n = 1'b0;
        #1;
        chk("arst_pc", 32'(pc), 32'd0);
        chk("arst_dv", 32'(dec_valid), 32'd0);
        chk("arst_ev", 32'(ex_valid), 32'd0);
        chk("arst_expc", 32'(ex_pc), 32'd0);
        chk("arst_ovf", 32'(stack_ovf), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("rel_ev", 32'(ex_valid), 32'd1);
        chk("rel_expc", 32'(ex_pc), 32'd0);

`ifdef CALL_STACK_EN
        do_redir("retempty", 1'b0, 1'b0, 1'b1, 12'h000, 12'h000);
        chk("retempty_ovf", 32'(stack_ovf), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
